// File: rtl/adc_frame_align.sv
module adc_frame_align #(
    parameter logic [5:0] PATTERN  = 6'b111000,
    parameter int         RST_LEN  = 4,
    parameter int         CAL_WAIT = 32,
    parameter int         SETTLE   = 8,
    parameter int         LOSS_LIM = 4,
    parameter int         DLY_TAPS = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [5:0] frame_i,
    output logic       srst_o,
    output logic       drst_o,
    output logic       dcal_o,
    output logic       dinc_o,
    output logic       bs_o,
    output logic       done_o,
    output logic       err_o,
    output logic       lost_o,
    output logic [2:0] slips_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTP,
        S_CAL,
        S_DLY,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam logic [7:0] RST_C  = 8'(RST_LEN - 1);
    localparam logic [7:0] CAL_C  = 8'(CAL_WAIT);
    localparam logic [7:0] SET_C  = 8'(SETTLE);
    localparam logic [3:0] LOSS_C = 4'(LOSS_LIM);
`ifdef FRAME_ALIGN_DELAY_EN
    localparam logic [7:0] TAPS_C = 8'(DLY_TAPS);
`endif

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] miss_q;
    logic [2:0] slips_q;
    logic       srst_q;
    logic       drst_q;
    logic       dcal_q;
    logic       bs_q;
    logic       done_q;
    logic       err_q;
    logic       lost_q;
`ifdef FRAME_ALIGN_DELAY_EN
    logic       dinc_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            miss_q  <= '0;
            slips_q <= '0;
            srst_q  <= 1'b0;
            drst_q  <= 1'b0;
            dcal_q  <= 1'b0;
            bs_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
`ifdef FRAME_ALIGN_DELAY_EN
            dinc_q  <= 1'b0;
`endif
        end else begin
            dcal_q <= 1'b0;
            bs_q   <= 1'b0;
            lost_q <= 1'b0;
            if (start_i) begin
                state_q <= S_RSTP;
                cnt_q   <= RST_C;
                srst_q  <= 1'b1;
                drst_q  <= 1'b1;
                slips_q <= '0;
                miss_q  <= '0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
`ifdef FRAME_ALIGN_DELAY_EN
                dinc_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_RSTP: begin
                        if (cnt_q == 8'd0) begin
                            srst_q  <= 1'b0;
                            drst_q  <= 1'b0;
                            dcal_q  <= 1'b1;
                            cnt_q   <= CAL_C;
                            state_q <= S_CAL;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    S_CAL: begin
                        if (cnt_q == 8'd0) begin
`ifdef FRAME_ALIGN_DELAY_EN
                            cnt_q   <= TAPS_C;
                            state_q <= S_DLY;
`else
                            cnt_q   <= SET_C;
                            state_q <= S_CHECK;
`endif
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
`ifdef FRAME_ALIGN_DELAY_EN
                    S_DLY: begin
                        if (dinc_q) begin
                            dinc_q <= 1'b0;
                        end else if (cnt_q == 8'd0) begin
                            cnt_q   <= SET_C;
                            state_q <= S_CHECK;
                        end else begin
                            dinc_q <= 1'b1;
                            cnt_q  <= cnt_q - 8'd1;
                        end
                    end
`endif
                    S_CHECK: begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end else if (frame_i == PATTERN) begin
                            miss_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_LOCKED;
                        end else if (slips_q < 3'd5) begin
                            bs_q    <= 1'b1;
                            slips_q <= slips_q + 3'd1;
                            state_q <= S_SLIP;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= S_FAIL;
                        end
                    end
                    S_SLIP: begin
                        cnt_q   <= SET_C;
                        state_q <= S_CHECK;
                    end
                    S_LOCKED: begin
                        if (frame_i == PATTERN) begin
                            miss_q <= '0;
                        end else if (miss_q + 4'd1 == LOSS_C) begin
                            lost_q  <= 1'b1;
                            done_q  <= 1'b0;
                            miss_q  <= '0;
                            slips_q <= '0;
                            srst_q  <= 1'b1;
                            drst_q  <= 1'b1;
                            cnt_q   <= RST_C;
                            state_q <= S_RSTP;
                        end else begin
                            miss_q <= miss_q + 4'd1;
                        end
                    end
                    S_FAIL: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign srst_o  = srst_q;
    assign drst_o  = drst_q;
    assign dcal_o  = dcal_q;
    assign bs_o    = bs_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign lost_o  = lost_q;
    assign slips_o = slips_q;
`ifdef FRAME_ALIGN_DELAY_EN
    assign dinc_o  = dinc_q;
`else
    assign dinc_o  = 1'b0;
`endif

endmodule

// File: tb/tb_adc_frame_align.sv
module tb_adc_frame_align;

    localparam logic [5:0] PAT = 6'b111000;
`ifdef FRAME_ALIGN_DELAY_EN
    localparam int TAPS  = 5;
    localparam int EXTRA = 2 * TAPS + 1;
`else
    localparam int TAPS  = 0;
    localparam int EXTRA = 0;
`endif
    localparam int T_CMP = 4 + 32 + 8 + 2 + EXTRA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] frame;
    logic       srst, drst, dcal, dinc, bs, done, err, lost;
    logic [2:0] slips;

    adc_frame_align #(.DLY_TAPS(TAPS)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .frame_i(frame),
        .srst_o(srst), .drst_o(drst), .dcal_o(dcal), .dinc_o(dinc),
        .bs_o(bs), .done_o(done), .err_o(err), .lost_o(lost), .slips_o(slips)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int t0 = 1 << 30;
    int srst_n, srst_first, dcal_n, dcal_at, dinc_n, dinc_first, dinc_last;
    int done_rise, slips_at_done, lost_n, lost_at, lost_ok, err_at;
    int bs_log[$];
    int viol = 0;
    logic prev_bs = 0, prev_dcal = 0, prev_dinc = 0, prev_done = 0, prev_err = 0;

    logic [5:0] base = PAT;
    int rot = 0;
    int corrupt_n = 0;

    function automatic logic [5:0] rotl6(input logic [5:0] v, input int n);
        logic [5:0] r = v;
        for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    function automatic int slips_needed(input logic [5:0] b);
        for (int k = 0; k < 6; k++) if (rotl6(b, k) == PAT) return k;
        return 6;
    endfunction

    task automatic clear_log();
        srst_n = 0; srst_first = -1; dcal_n = 0; dcal_at = -1;
        dinc_n = 0; dinc_first = -1; dinc_last = -1;
        done_rise = -1; slips_at_done = -1; lost_n = 0; lost_at = -1; lost_ok = 0; err_at = -1;
        bs_log.delete();
        t0 = cyc;
    endtask

    initial begin
        frame = PAT;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (32'(bs) + 32'(dcal) + 32'(dinc) + 32'(srst) > 1) viol++;
                if ((bs && prev_bs) || (dcal && prev_dcal) || (dinc && prev_dinc)) viol++;
                if (cyc > t0) begin
                    if (srst) begin srst_n++; if (srst_first < 0) srst_first = cyc; end
                    if (dcal) begin dcal_n++; dcal_at = cyc; end
                    if (dinc) begin dinc_n++; if (dinc_first < 0) dinc_first = cyc; dinc_last = cyc; end
                    if (bs) bs_log.push_back(cyc);
                    if (done && !prev_done) begin done_rise = cyc; slips_at_done = int'(slips); end
                    if (err && !prev_err) err_at = cyc;
                    if (lost) begin lost_n++; lost_at = cyc; lost_ok = int'(srst && !done); end
                end
            end
            prev_bs = bs; prev_dcal = dcal; prev_dinc = dinc; prev_done = done; prev_err = err;
            if (bs) rot = (rot + 1) % 6;
            if (corrupt_n > 0) begin
                frame = ~PAT;
                corrupt_n--;
            end else begin
                frame = rotl6(base, rot);
            end
        end
    end

    task automatic start_train();
        @(posedge clk); #2;
        clear_log();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc < t0 + n) @(posedge clk);
        #2;
    endtask

    task automatic run_train(input string tag);
        int k;
        k = slips_needed(rotl6(base, rot));
        start_train();
        wait_rel(T_CMP + 10 * k + 4);
        check_eq({tag, " srst_len"}, srst_n, 4);
        check_eq({tag, " srst_first"}, srst_first - t0, 1);
        check_eq({tag, " dcal_cnt"}, dcal_n, 1);
        check_eq({tag, " dcal_at"}, dcal_at - t0, 5);
        check_eq({tag, " bs_cnt"}, bs_log.size(), k);
        foreach (bs_log[i]) check_eq({tag, " bs_at"}, bs_log[i] - t0, T_CMP + 1 + 10 * i);
        check_eq({tag, " done_at"}, done_rise - t0, T_CMP + 1 + 10 * k);
        check_eq({tag, " slips"}, slips_at_done, k);
        check_eq({tag, " err"}, err, 0);
`ifdef FRAME_ALIGN_DELAY_EN
        check_eq({tag, " dinc_cnt"}, dinc_n, TAPS);
        check_eq({tag, " dinc_first"}, dinc_first - t0, 39);
        check_eq({tag, " dinc_last"}, dinc_last - t0, 39 + 2 * (TAPS - 1));
`else
        check_eq({tag, " dinc_cnt"}, dinc_n, 0);
`endif
        $display("train %s: slips=%0d done_at=+%0d", tag, slips_at_done, done_rise - t0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k, len;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_outputs", {srst, drst, dcal, dinc, bs, done, err, lost, slips}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        base = PAT; rot = 0;
        run_train("aligned");

        base = rotl6(PAT, 3); rot = 0;
        run_train("slip3");

        @(posedge clk); #2;
        corrupt_n = 3;
        repeat (10) @(posedge clk);
        #2;
        check_eq("glitch3_done", done, 1);
        check_eq("glitch3_lost", lost_n, 0);
        $display("glitch len=3: done=%0d lost=%0d", done, lost_n);

        @(posedge clk); #2;
        c = cyc;
        corrupt_n = 4;
        while (cyc < c + 4 + 46 + EXTRA + 3) @(posedge clk);
        #2;
        check_eq("loss_lost_cnt", lost_n, 1);
        check_eq("loss_lost_at", lost_at - c, 4);
        check_eq("loss_srst_nodone", lost_ok, 1);
        check_eq("relock_done_at", done_rise - lost_at, 46 + EXTRA);
        check_eq("relock_slips", slips_at_done, 0);
        check_eq("relock_bs_cnt", bs_log.size(), 3);
        $display("glitch len=4: lost_at=+%0d relock=+%0d", lost_at - c, done_rise - c);

        base = 6'b101010; rot = 0;
        start_train();
        wait_rel(T_CMP + 50 + 3);
        check_eq("nolock_bs_cnt", bs_log.size(), 5);
        check_eq("nolock_err_at", err_at - t0, T_CMP + 51);
        check_eq("nolock_done", done, 0);
        repeat (20) @(posedge clk);
        #2;
        check_eq("nolock_err_sticky", err, 1);
        check_eq("nolock_bs_after", bs_log.size(), 5);
        $display("train no-lock: bs=%0d err=%0d", bs_log.size(), err);
        base = PAT; rot = 0;
        start_train();
        check_eq("restart_err_clr", err, 0);
        check_eq("restart_srst", srst, 1);
        wait_rel(T_CMP + 4);
        check_eq("restart_done", done, 1);

        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(0, 5);
            base = rotl6(PAT, (6 - k) % 6); rot = 0;
            run_train("random");
            len = $urandom_range(1, 3);
            @(posedge clk); #2;
            corrupt_n = len;
            repeat (8) @(posedge clk);
            #2;
            check_eq("rand_glitch_done", done, 1);
            check_eq("rand_glitch_lost", lost_n, 0);
            $display("random glitch len=%0d: done=%0d", len, done);
        end

        base = rotl6(PAT, 3); rot = 0;
        start_train();
        k = 0;
        for (int i = 0; i < 200 && k == 0; i++) begin
            @(posedge clk); #2;
            if (bs) k = 1;
        end
        check_eq("midslip_bs_seen", k, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midslip_outputs", {srst, drst, dcal, dinc, bs, done, err, lost, slips}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_eq("midslip_idle", {srst, drst, dcal, dinc, bs, done, err, lost, slips}, 0);
        $display("reset mid-slip: outputs=%0d", {srst, drst, dcal, dinc, bs, done, err, lost, slips});

        check_eq("pulse_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
